// File: rtl/cdc_fifo_pkg.sv
// Shared pointer helpers for both sides of the dual-clock FIFO.
// Latency: n/a (pure functions and constants).
// Backpressure: n/a.
// Contents: bin2gray / gray2bin on a PTR_MAX_W-bit container. Narrower pointers
//           are zero-extended in and truncated out. SYNC_STAGES bounds.
package cdc_fifo_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int PTR_MAX_W       = 32;

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Zero-extended inputs decode correctly because the leading zeros stay zero.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
        logic [PTR_MAX_W-1:0] bin;
        bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/cdc_fifo_read_state_if.sv
// Read-side output stream of the dual-clock FIFO: a word plus valid/ready.
// Latency: n/a (wires only).
// Backpressure: the consumer holds read_ready low to stall the stream.
// Modports: master = FIFO (drives data and valid), slave = consumer (drives ready).
interface cdc_fifo_read_state_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] read_data;
    logic                  read_valid;
    logic                  read_ready;

    modport master (output read_data, output read_valid, input read_ready);
    modport slave  (input read_data, input read_valid, output read_ready);
endinterface

// File: rtl/cdc_gray_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer entering a new clock domain.
// Latency: STAGES clocks from the input to data_o.
// Backpressure: none. The chain samples every clock.
// Ports: clock, reset (async, active-high), data_i (async Gray), data_o (synchronised).
module cdc_gray_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= data_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign data_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_fifo_read_state.sv
// Read-domain half of the dual-clock FIFO, with a registered FWFT valid/ready output stage.
// Latency: a write pointer change appears on empty after SYNC_STAGES clocks and on read_valid one clock later.
// Backpressure: when read_ready is low with read_valid high, data, valid and the read pointer all hold.
// Ports: clock/reset (async, active-high); write_address_gray_i (from write domain);
//        mem_read_data_i (comb storage read); rd_if (output stream); read_address_o,
//        read_address_gray_o (to write domain), empty_o, read_level_o.
module cdc_fifo_read_state
    import cdc_fifo_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-1:0] write_address_gray_i,
    input  logic [DATA_WIDTH-1:0]    mem_read_data_i,
    cdc_fifo_read_state_if.master    rd_if,
    output logic [ADDRESS_WIDTH-1:0] read_address_o,
    output logic [ADDRESS_WIDTH-1:0] read_address_gray_o,
    output logic                     empty_o,
    output logic [ADDRESS_WIDTH-1:0] read_level_o
);

    localparam int AW = ADDRESS_WIDTH;

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
        $error("cdc_fifo_read_state: SYNC_STAGES must be in 2..4");
    end

    logic [AW-1:0]         wr_gray_sync;
    logic [AW-1:0]         wr_bin_sync;
    logic [AW-1:0]         rd_addr_q, rd_addr_d;
    logic [AW-1:0]         rd_gray_q, rd_gray_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic [AW-1:0]         rd_addr_inc;
    logic                  empty;
    logic                  load;

    // The Gray write pointer is the only signal crossing into this domain.
    cdc_gray_sync #(
        .WIDTH  (AW),
        .STAGES (SYNC_STAGES)
    ) u_wr_ptr_sync (
        .clock  (clock),
        .reset  (reset),
        .data_i (write_address_gray_i),
        .data_o (wr_gray_sync)
    );

    assign wr_bin_sync = AW'(gray2bin(PTR_MAX_W'(wr_gray_sync)));

    // A stale synchronised pointer lags the true one, so empty can only be late to clear.
    assign empty       = (rd_addr_q == wr_bin_sync);
    assign rd_addr_inc = rd_addr_q + 1'b1;

    // Refill the output register when it is free or is being drained this cycle.
    assign load = !empty && (!valid_q || rd_if.read_ready);

    always_comb begin
        rd_addr_d = rd_addr_q;
        rd_gray_d = rd_gray_q;
        data_d    = data_q;
        valid_d   = valid_q;
        if (load) begin
            data_d    = mem_read_data_i;
            valid_d   = 1'b1;
            rd_addr_d = rd_addr_inc;
            // Registered so the write domain never samples a decode glitch.
            rd_gray_d = AW'(bin2gray(PTR_MAX_W'(rd_addr_inc)));
        end else if (valid_q && rd_if.read_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_addr_q <= '0;
            rd_gray_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            rd_addr_q <= rd_addr_d;
            rd_gray_q <= rd_gray_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
        end
    end

    assign rd_if.read_data     = data_q;
    assign rd_if.read_valid    = valid_q;
    assign read_address_o      = rd_addr_q;
    assign read_address_gray_o = rd_gray_q;
    assign empty_o             = empty;
    assign read_level_o        = wr_bin_sync - rd_addr_q;

endmodule
